// File: rtl/pe_array_ws_db.sv
`default_nettype none
// pe_array_ws_db: weight-stationary ROWS x COLS signed MAC array with shadow weight
// banks, a skew-aligned bank swap, per-column bias injection and valid tracking.
module pe_array_ws_db #(
  parameter int ROWS       = 16,
  parameter int COLS       = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ROW_IDX_W  = $clog2(ROWS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wt_valid,
  output logic                           wt_ready,
  input  logic [ROW_IDX_W-1:0]           wt_row,
  input  logic [COLS*DATA_WIDTH-1:0]     wt_data,
  input  logic                           wt_swap,
  input  logic                           in_valid,
  input  logic [ROWS*DATA_WIDTH-1:0]     in_data,
  input  logic [COLS*ACC_WIDTH-1:0]      bias_in,
  output logic                           out_valid,
  output logic [COLS*ACC_WIDTH-1:0]      out_data,
  output logic                           busy,
  output logic                           swap_busy
);

  logic [ROWS-1:0]               row_tok;
  logic [ROWS-1:0]               bank_sel_q;
  logic [ROWS-1:1]               tok_q;
  logic [ROWS-1:0]               vld_q;
  logic                          wt_fire;
  logic [COLS*DATA_WIDTH-1:0]    bank0_q [ROWS];
  logic [COLS*DATA_WIDTH-1:0]    bank1_q [ROWS];
  logic [COLS*ACC_WIDTH-1:0]     psum_q  [ROWS];

  function automatic logic signed [ACC_WIDTH-1:0] mac(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    return acc + ACC_WIDTH'(p);
  endfunction

  // A swap token sits at row r during cycle T+r; no load may land while any token is live.
  assign row_tok   = {tok_q, wt_swap};
  assign swap_busy = |tok_q;
  assign wt_ready  = ~swap_busy & ~wt_swap;
  assign wt_fire   = wt_valid & wt_ready;

  assign out_valid = vld_q[ROWS-1];
  assign busy      = |vld_q[ROWS-2:0];
  assign out_data  = psum_q[ROWS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      tok_q      <= '0;
      bank_sel_q <= '0;
    end else begin
      vld_q      <= {vld_q[ROWS-2:0], in_valid};
      tok_q      <= row_tok[ROWS-2:0];
      bank_sel_q <= bank_sel_q ^ row_tok;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [DATA_WIDTH-1:0] in_gated;
    logic signed [DATA_WIDTH-1:0] row_data;
    logic [COLS*ACC_WIDTH-1:0]    psum_in;
    logic [COLS*DATA_WIDTH-1:0]   w_eff;

    assign in_gated = in_valid ? in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    // While a token is at this row it reads the shadow bank, which becomes active next cycle.
    assign w_eff = (bank_sel_q[r] ^ row_tok[r]) ? bank1_q[r] : bank0_q[r];

    if (r == 0) begin : g_top
      assign row_data = in_gated;
      assign psum_in  = in_valid ? bias_in : '0;
    end else begin : g_skew
      logic signed [DATA_WIDTH-1:0] dly_q [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < r; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= in_gated;
          for (int k = 1; k < r; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign row_data = dly_q[r-1];
      assign psum_in  = psum_q[r-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        bank0_q[r] <= '0;
        bank1_q[r] <= '0;
      end else if (wt_fire && (wt_row == ROW_IDX_W'(r))) begin
        if (bank_sel_q[r]) bank0_q[r] <= wt_data;
        else               bank1_q[r] <= wt_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        psum_q[r] <= '0;
      end else begin
        for (int c = 0; c < COLS; c++) begin
          psum_q[r][c*ACC_WIDTH +: ACC_WIDTH] <= mac(psum_in[c*ACC_WIDTH +: ACC_WIDTH],
                                                     row_data,
                                                     w_eff[c*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
    end
  end

endmodule
`default_nettype wire
